usb_uart_tx_arbiter: RTL

//   Shares the single USB UART transmit byte port between NUM_REQ requesters.

---
 rtl/usb_uart_tx_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/usb_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares the USB UART TX byte port
// between NUM_REQ producers, with idle-timeout release and UART-reset hold-off.

module usb_uart_tx_arb_lane (
  input  logic i_sel,
  input  logic i_en,
  input  logic i_valid,
  input  logic i_tx_ready,
  output logic o_valid,
  output logic o_ready
);
  assign o_valid = i_en & i_sel & i_valid;
  assign o_ready = i_en & i_sel & i_tx_ready;
endmodule

module usb_uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 4800
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_uart_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_byte_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_timeout_pulse
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [IW-1:0]        r_owner, w_owner_nxt;
  logic [IW-1:0]        r_last_win, w_last_win_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic                 w_en;
  logic [NUM_REQ-1:0]   w_lane_valid;
  logic [NUM_REQ-1:0][7:0] w_bytes;
  logic                 w_owner_valid;
  logic                 w_xfer;
  logic                 w_found;
  logic [IW-1:0]        w_pick;

  assign w_en    = (r_state == S_LOCKED) & ~i_uart_reset;
  assign w_bytes = i_req_byte;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    usb_uart_tx_arb_lane u_lane (
      .i_sel      (r_grant[g]),
      .i_en       (w_en),
      .i_valid    (i_req_valid[g]),
      .i_tx_ready (i_tx_ready),
      .o_valid    (w_lane_valid[g]),
      .o_ready    (o_req_ready[g])
    );
  end

  assign o_tx_byte_valid = |w_lane_valid;
  assign o_tx_byte       = w_en ? w_bytes[r_owner] : 8'h00;
  assign o_grant         = r_grant;
  assign o_timeout_pulse = r_timeout;
  assign w_owner_valid   = i_req_valid[r_owner];
  assign w_xfer          = o_tx_byte_valid & i_tx_ready;

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    logic [IW-1:0] w_idx;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(r_last_win) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_last_win_nxt = r_last_win;
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!i_uart_reset && w_found) begin
          w_state_nxt         = S_LOCKED;
          w_owner_nxt         = w_pick;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
        end
      end
      S_LOCKED: begin
        if (i_uart_reset) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_xfer && i_req_last[r_owner]) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_last_win_nxt = r_owner;
          w_cnt_nxt      = '0;
        end else if (w_owner_valid) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(IDLE_TIMEOUT - 1)) begin
          // This idle cycle is the IDLE_TIMEOUT-th in a row: force release.
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_last_win_nxt = r_owner;
          w_cnt_nxt      = '0;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_last_win <= IW'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_last_win <= w_last_win_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end
endmodule
